cussen_decoder: RTL and testbench
=================================

Name: cussen_decoder

Overview:
- Inverse of the cussen unique-value compressor: rebuilds the 9-entry 8-bit input vector from the compressor's dictionary (out1..out9), per-slot pointers (pointer1..pointer9) and unique_count.
- Sits on the consumer side of the compressed link; drives a serial valid/ready element stream and a parallel registered result vector.
- Flags any out-of-range pointer.

Parameters:
- DATA_W, 8, width of each data element and dictionary entry
- PTR_W, 4, width of each pointer and of unique_count

Ports:
- clk  input  1  system clock, rising edge
- rst_n  input  1  asynchronous active-low reset
- start  input  1  one-cycle request; captures dictionary, pointers and count when in IDLE
- dict1..dict9  input  DATA_W each  dictionary entries 0..8, in compressor out1..out9 order
- ptr1..ptr9  input  PTR_W each  0-based dictionary index for slot 1..9
- unique_count  input  PTR_W  number of valid dictionary entries, legal range 1..9
- busy  output  1  high from the cycle after an accepted start until the cycle after done
- stream_data  output  DATA_W  current reconstructed element
- stream_idx  output  PTR_W  slot index 0..8 of stream_data
- stream_valid  output  1  stream_data/stream_idx valid
- stream_ready  input  1  downstream accepts the element this cycle
- out1..out9  output  DATA_W each  registered reconstructed vector
- done  output  1  one-cycle pulse after slot 9 is accepted
- error  output  1  stays high from done until the next accepted start; set if any pointer >= unique_count, or if unique_count is 0 or greater than 9

Behaviour:
- Reset, asynchronous on rst_n low: FSM=IDLE; busy, stream_valid, done and error are 0; stream_data, stream_idx and out1..out9 are 0; the captured register file is cleared.
- A reset mid-frame aborts the frame. No partial done is produced.
- FSM states: IDLE, DECODE, FINISH.
- IDLE:
  - start=1 captures all dict/ptr/unique_count into internal registers and sets idx=0.
  - Next state is DECODE and busy rises.
  - start=0 keeps the FSM in IDLE.
- DECODE:
  - stream_valid=1, stream_idx=idx.
  - stream_data = captured dict[ptr[idx]] when ptr[idx] < unique_count and unique_count is in 1..9. Otherwise stream_data = 0 and an internal err bit is set.
  - On stream_valid & stream_ready, out(idx+1) is written with stream_data and idx increments.
  - When idx=8 is accepted, the next state is FINISH.
  - When stream_ready=0, stream_data, stream_idx and stream_valid hold stable. No element may be dropped or repeated.
- FINISH:
  - Lasts one cycle: done=1, stream_valid=0, error=err.
  - Next state is IDLE, and busy falls on the same edge.
- Latency with stream_ready held at 1 and start sampled at edge T:
  - slot k (0..8) is valid in cycle T+1+k
  - done is high in cycle T+10
  - busy is high for cycles T+1..T+10
- start while busy is ignored. The captured data is unaffected by input changes during the frame.
- start in the FINISH cycle is ignored. start in the first IDLE cycle after FINISH is accepted, so back-to-back frames have a one-cycle gap.
- out1..out9:
  - hold their previous frame values until overwritten slot by slot; not cleared at start.
  - all nine are final when done=1.
- error:
  - cleared on accepted start.
  - updated at FINISH.
  - held until the next accepted start.
- Dictionary entries at index >= unique_count are never selected by a legal frame.
- Duplicate pointers are legal: several slots may reference the same entry.

Test Plan:
- Round trip: dict=3,1,4,5,9,0,0,0,0; ptr=0,1,2,1,3,4,1,1,1; unique_count=5; stream_ready=1 -> stream 3,1,4,1,5,9,1,1,1 in cycles T+1..T+9; out1..out9 match; done at T+10; error=0.
- Backpressure: same frame, stream_ready low for 3 cycles while slot 2 is presented -> stream_data=4 and stream_idx=2 held; done at T+13; no loss or duplication.
- Bad pointer: unique_count=5, ptr5=7 -> slot 4 emits 0, other slots correct, error=1 with done and held until the next start.
- Zero count: unique_count=0 -> all nine slots emit 0; error=1.
- Start while busy: second start at T+4 with different dict -> ignored, first frame completes unchanged. A start at T+11 is accepted and busy rises at T+12.
- Mid-frame reset: rst_n low at T+5 -> busy, stream_valid and outputs are 0 immediately; no done pulse; a fresh start after release decodes correctly.

Source files
------------

// File: rtl/cussen_decoder.sv
// cussen_decoder
// Rebuilds the 9-entry vector produced by the cussen unique-value compressor
// from its dictionary, per-slot pointers and unique-entry count.  Elements are
// emitted one per accepted valid/ready handshake and also written into a
// registered parallel result vector.
//
// Ports
//   clk, rst_n            system clock, async active-low reset
//   start                 frame request, honoured only in IDLE
//   dict1..dict9          dictionary entries 0..8
//   ptr1..ptr9            0-based dictionary index for slots 1..9
//   unique_count          valid dictionary entries (legal 1..9)
//   busy                  frame in progress (DECODE or FINISH)
//   stream_data/idx/valid current element, held while stream_ready is low
//   stream_ready          downstream accepts the current element
//   out1..out9            registered reconstructed vector
//   done                  one-cycle pulse after slot 9 is accepted
//   error                 bad pointer or count seen in the last frame
//
// state    | meaning
// S_IDLE   | waiting for start; captured frame registers hold
// S_DECODE | presenting slot r_idx on the stream until accepted
// S_FINISH | single cycle: done pulse, error published
module cussen_decoder #(
   parameter int DATA_W = 8,
   parameter int PTR_W  = 4
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              start,
   input  logic [DATA_W-1:0] dict1, dict2, dict3, dict4, dict5, dict6, dict7, dict8, dict9,
   input  logic [PTR_W-1:0]  ptr1, ptr2, ptr3, ptr4, ptr5, ptr6, ptr7, ptr8, ptr9,
   input  logic [PTR_W-1:0]  unique_count,
   output logic              busy,
   output logic [DATA_W-1:0] stream_data,
   output logic [PTR_W-1:0]  stream_idx,
   output logic              stream_valid,
   input  logic              stream_ready,
   output logic [DATA_W-1:0] out1, out2, out3, out4, out5, out6, out7, out8, out9,
   output logic              done,
   output logic              error
);

   typedef enum logic [1:0] {S_IDLE, S_DECODE, S_FINISH} state_t;

   state_t            r_state, w_next;
   logic [DATA_W-1:0] r_dict [9];
   logic [PTR_W-1:0]  r_ptr  [9];
   logic [DATA_W-1:0] r_out  [9];
   logic [PTR_W-1:0]  r_cnt;
   logic [PTR_W-1:0]  r_idx;
   logic              r_err;
   logic              r_error;

   logic [DATA_W-1:0] w_dict_in [9];
   logic [PTR_W-1:0]  w_ptr_in  [9];
   logic [PTR_W-1:0]  w_ptr;
   logic [DATA_W-1:0] w_sel;
   logic              w_cnt_ok, w_bad, w_accept, w_last, w_capture;

   assign w_dict_in = '{dict1, dict2, dict3, dict4, dict5, dict6, dict7, dict8, dict9};
   assign w_ptr_in  = '{ptr1, ptr2, ptr3, ptr4, ptr5, ptr6, ptr7, ptr8, ptr9};

   // Mux-by-compare keeps every lookup in range even for 4-bit pointers > 8.
   always_comb begin
      w_ptr = '0;
      for (int i = 0; i < 9; i++)
         if (r_idx == PTR_W'(i)) w_ptr = r_ptr[i];
      w_sel = '0;
      for (int i = 0; i < 9; i++)
         if (w_ptr == PTR_W'(i)) w_sel = r_dict[i];
   end

   assign w_cnt_ok  = (r_cnt != '0) && (r_cnt <= PTR_W'(9));
   assign w_bad     = !w_cnt_ok || (w_ptr >= r_cnt);
   assign w_capture = (r_state == S_IDLE) && start;
   assign w_accept  = (r_state == S_DECODE) && stream_ready;
   assign w_last    = (r_idx == PTR_W'(8));

   always_comb begin
      w_next = r_state;
      case (r_state)
         S_IDLE:   if (start) w_next = S_DECODE;
         S_DECODE: if (stream_ready && w_last) w_next = S_FINISH;
         S_FINISH: w_next = S_IDLE;
         default:  w_next = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) r_state <= S_IDLE;
      else        r_state <= w_next;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < 9; i++) begin
            r_dict[i] <= '0;
            r_ptr[i]  <= '0;
            r_out[i]  <= '0;
         end
         r_cnt   <= '0;
         r_idx   <= '0;
         r_err   <= 1'b0;
         r_error <= 1'b0;
      end else begin
         if (w_capture) begin
            for (int i = 0; i < 9; i++) begin
               r_dict[i] <= w_dict_in[i];
               r_ptr[i]  <= w_ptr_in[i];
            end
            r_cnt   <= unique_count;
            r_idx   <= '0;
            r_err   <= 1'b0;
            r_error <= 1'b0;
         end
         if (w_accept) begin
            for (int i = 0; i < 9; i++)
               if (r_idx == PTR_W'(i)) r_out[i] <= stream_data;
            r_idx <= r_idx + 1'b1;
            r_err <= r_err | w_bad;
            // Publish on the last acceptance so error is already valid with done.
            if (w_last) r_error <= r_err | w_bad;
         end
      end
   end

   assign busy         = (r_state != S_IDLE);
   assign stream_valid = (r_state == S_DECODE);
   assign stream_idx   = stream_valid ? r_idx : '0;
   assign stream_data  = (stream_valid && !w_bad) ? w_sel : '0;
   assign done         = (r_state == S_FINISH);
   assign error        = r_error;

   assign out1 = r_out[0];
   assign out2 = r_out[1];
   assign out3 = r_out[2];
   assign out4 = r_out[3];
   assign out5 = r_out[4];
   assign out6 = r_out[5];
   assign out7 = r_out[6];
   assign out8 = r_out[7];
   assign out9 = r_out[8];

endmodule

// File: tb/tb_cussen_decoder.sv
// Directed bench for cussen_decoder: table of whole frames with hand-computed
// streams, plus sequences for backpressure, start-while-busy and reset.
module tb_cussen_decoder;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       start = 1'b0;
   logic       stream_ready = 1'b1;
   logic [7:0] t_dict [9];
   logic [3:0] t_ptr  [9];
   logic [3:0] t_cnt;
   logic       busy, stream_valid, done, error;
   logic [7:0] stream_data;
   logic [3:0] stream_idx;
   logic [7:0] o_out [9];

   int n_checks = 0;
   int n_fail   = 0;

   always #5 clk = ~clk;

   cussen_decoder #(.DATA_W(8), .PTR_W(4)) dut (
      .clk(clk), .rst_n(rst_n), .start(start),
      .dict1(t_dict[0]), .dict2(t_dict[1]), .dict3(t_dict[2]), .dict4(t_dict[3]),
      .dict5(t_dict[4]), .dict6(t_dict[5]), .dict7(t_dict[6]), .dict8(t_dict[7]),
      .dict9(t_dict[8]),
      .ptr1(t_ptr[0]), .ptr2(t_ptr[1]), .ptr3(t_ptr[2]), .ptr4(t_ptr[3]),
      .ptr5(t_ptr[4]), .ptr6(t_ptr[5]), .ptr7(t_ptr[6]), .ptr8(t_ptr[7]),
      .ptr9(t_ptr[8]),
      .unique_count(t_cnt),
      .busy(busy), .stream_data(stream_data), .stream_idx(stream_idx),
      .stream_valid(stream_valid), .stream_ready(stream_ready),
      .out1(o_out[0]), .out2(o_out[1]), .out3(o_out[2]), .out4(o_out[3]),
      .out5(o_out[4]), .out6(o_out[5]), .out7(o_out[6]), .out8(o_out[7]),
      .out9(o_out[8]),
      .done(done), .error(error)
   );

   typedef struct {
      logic [0:8][7:0] dict;
      logic [0:8][3:0] ptr;
      logic [3:0]      cnt;
      logic [0:8][7:0] exp;
      logic            err;
   } vec_t;

   vec_t vecs [7];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Advance one clock; sampling and driving happen 1 time unit after the edge.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic load(input int v);
      for (int i = 0; i < 9; i++) begin
         t_dict[i] = vecs[v].dict[i];
         t_ptr[i]  = vecs[v].ptr[i];
      end
      t_cnt = vecs[v].cnt;
   endtask

   // Full frame with stream_ready high; start sampled at edge T.
   task automatic run_frame(input int v);
      load(v);
      start = 1'b1;
      tick();
      start = 1'b0;
      chk("busy_rise", busy, 1);
      chk("err_clr", error, 0);
      for (int k = 0; k < 9; k++) begin
         chk("valid", stream_valid, 1);
         chk("idx", stream_idx, k);
         chk("data", stream_data, vecs[v].exp[k]);
         chk("no_done", done, 0);
         tick();
      end
      chk("done", done, 1);
      chk("valid_fin", stream_valid, 0);
      chk("busy_fin", busy, 1);
      chk("err_done", error, vecs[v].err);
      for (int k = 0; k < 9; k++) chk("out", o_out[k], vecs[v].exp[k]);
      tick();
      chk("busy_fall", busy, 0);
      chk("done_fall", done, 0);
      chk("err_hold", error, vecs[v].err);
   endtask

   initial begin
      vecs[0] = '{dict: {8'd3, 8'd1, 8'd4, 8'd5, 8'd9, 8'd0, 8'd0, 8'd0, 8'd0},
                  ptr:  {4'd0, 4'd1, 4'd2, 4'd1, 4'd3, 4'd4, 4'd1, 4'd1, 4'd1}, cnt: 4'd5,
                  exp:  {8'd3, 8'd1, 8'd4, 8'd1, 8'd5, 8'd9, 8'd1, 8'd1, 8'd1}, err: 1'b0};
      vecs[1] = '{dict: {8'd3, 8'd1, 8'd4, 8'd5, 8'd9, 8'd0, 8'd0, 8'd0, 8'd0},
                  ptr:  {4'd0, 4'd1, 4'd2, 4'd1, 4'd7, 4'd4, 4'd1, 4'd1, 4'd1}, cnt: 4'd5,
                  exp:  {8'd3, 8'd1, 8'd4, 8'd1, 8'd0, 8'd9, 8'd1, 8'd1, 8'd1}, err: 1'b1};
      vecs[2] = '{dict: {8'd3, 8'd1, 8'd4, 8'd5, 8'd9, 8'd0, 8'd0, 8'd0, 8'd0},
                  ptr:  {4'd0, 4'd1, 4'd2, 4'd1, 4'd3, 4'd4, 4'd1, 4'd1, 4'd1}, cnt: 4'd0,
                  exp:  {8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0}, err: 1'b1};
      vecs[3] = '{dict: {8'h11, 8'h12, 8'h13, 8'h14, 8'h15, 8'h16, 8'h17, 8'h18, 8'h19},
                  ptr:  {4'd0, 4'd1, 4'd2, 4'd3, 4'd4, 4'd5, 4'd6, 4'd7, 4'd8}, cnt: 4'd10,
                  exp:  {8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0}, err: 1'b1};
      vecs[4] = '{dict: {8'hA0, 8'hA1, 8'hA2, 8'hA3, 8'hA4, 8'hA5, 8'hA6, 8'hA7, 8'hA8},
                  ptr:  {4'd8, 4'd7, 4'd6, 4'd5, 4'd4, 4'd3, 4'd2, 4'd1, 4'd0}, cnt: 4'd9,
                  exp:  {8'hA8, 8'hA7, 8'hA6, 8'hA5, 8'hA4, 8'hA3, 8'hA2, 8'hA1, 8'hA0}, err: 1'b0};
      vecs[5] = '{dict: {8'h55, 8'hEE, 8'hEE, 8'hEE, 8'hEE, 8'hEE, 8'hEE, 8'hEE, 8'hEE},
                  ptr:  {4'd0, 4'd0, 4'd0, 4'd0, 4'd0, 4'd0, 4'd0, 4'd0, 4'd0}, cnt: 4'd1,
                  exp:  {8'h55, 8'h55, 8'h55, 8'h55, 8'h55, 8'h55, 8'h55, 8'h55, 8'h55}, err: 1'b0};
      vecs[6] = '{dict: {8'd10, 8'd20, 8'd30, 8'd40, 8'd50, 8'd60, 8'd70, 8'd80, 8'd90},
                  ptr:  {4'd2, 4'd1, 4'd0, 4'd3, 4'd0, 4'd0, 4'd0, 4'd0, 4'd0}, cnt: 4'd3,
                  exp:  {8'd30, 8'd20, 8'd10, 8'd0, 8'd10, 8'd10, 8'd10, 8'd10, 8'd10}, err: 1'b1};
      load(0);

      #12;
      chk("rst_busy", busy, 0);
      chk("rst_valid", stream_valid, 0);
      chk("rst_done", done, 0);
      chk("rst_error", error, 0);
      chk("rst_data", stream_data, 0);
      chk("rst_out9", o_out[8], 0);
      rst_n = 1'b1;
      tick();
      chk("idle_hold", busy, 0);

      for (int v = 0; v < 7; v++) run_frame(v);

      // Backpressure: slot 2 stalled for three cycles; done expected at T+13.
      begin
         int k = 0, stall = 0, cyc = 1;
         load(0);
         start = 1'b1;
         tick();
         start = 1'b0;
         while (k < 9 && cyc < 40) begin
            chk("bp_valid", stream_valid, 1);
            chk("bp_idx", stream_idx, k);
            chk("bp_data", stream_data, vecs[0].exp[k]);
            stream_ready = !(k == 2 && stall < 3);
            tick();
            if (stream_ready) k++;
            else stall++;
            cyc++;
         end
         stream_ready = 1'b1;
         chk("bp_done_cycle", cyc, 13);
         chk("bp_done", done, 1);
         for (int i = 0; i < 9; i++) chk("bp_out", o_out[i], vecs[0].exp[i]);
         tick();
      end

      // Start while busy is ignored; start in FINISH is ignored; next IDLE start is taken.
      load(0);
      start = 1'b1;
      tick();
      start = 1'b0;
      for (int k = 0; k < 9; k++) begin
         if (k == 3) begin
            load(4);
            start = 1'b1;
         end else begin
            start = 1'b0;
         end
         chk("sb_data", stream_data, vecs[0].exp[k]);
         chk("sb_idx", stream_idx, k);
         tick();
      end
      chk("sb_done", done, 1);
      chk("sb_err", error, 0);
      start = 1'b1;
      tick();
      chk("sb_fin_ignored", busy, 0);
      tick();
      start = 1'b0;
      chk("sb_restart", busy, 1);
      chk("sb_new_data", stream_data, vecs[4].exp[0]);
      for (int k = 0; k < 10; k++) tick();
      chk("sb_idle", busy, 0);

      // Mid-frame reset: frame aborts immediately, no done, then a fresh frame decodes.
      load(1);
      start = 1'b1;
      tick();
      start = 1'b0;
      for (int k = 0; k < 4; k++) tick();
      rst_n = 1'b0;
      #1;
      chk("mr_busy", busy, 0);
      chk("mr_valid", stream_valid, 0);
      chk("mr_data", stream_data, 0);
      chk("mr_out1", o_out[0], 0);
      chk("mr_error", error, 0);
      tick();
      rst_n = 1'b1;
      begin
         int seen = 0;
         for (int k = 0; k < 12; k++) begin
            if (done) seen++;
            tick();
         end
         chk("mr_no_done", seen, 0);
      end
      run_frame(0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout: simulation exceeded time limit");
      $fatal(1, "timeout");
   end

endmodule
